// File: rtl/lcd_img_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : lcd_img_ctrl_p
// Purpose  : Parametrised LCD image controller. Loads an IMG_W x IMG_H image
//            from IROM, applies host commands to a movable 2x2 window
//            (shift, max/min/average fill, rotate, mirror) and streams the
//            image to IRAM on request.
// Options  : LCD_MEDIAN_EN - when defined, cmd 12 performs a median fill.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_img_ctrl_p #(
    parameter  int DW     = 8,
    parameter  int W_LOG2 = 3,
    parameter  int H_LOG2 = 3,
    localparam int AW     = W_LOG2 + H_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    output logic          IRAM_valid,
    output logic [DW-1:0] IRAM_D,
    output logic [AW-1:0] IRAM_A,
    output logic          busy,
    output logic          done
);

    localparam int N = 1 << AW;
    localparam logic [AW-1:0]     C_LAST    = AW'(N - 1);
    localparam logic [H_LOG2-1:0] C_ROW_RST = H_LOG2'((1 << (H_LOG2 - 1)) - 1);
    localparam logic [W_LOG2-1:0] C_COL_RST = W_LOG2'((1 << (W_LOG2 - 1)) - 1);
    localparam logic [H_LOG2-1:0] C_ROW_MAX = H_LOG2'((1 << H_LOG2) - 2);
    localparam logic [W_LOG2-1:0] C_COL_MAX = W_LOG2'((1 << W_LOG2) - 2);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_IDLE  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t              r_state;
    logic [H_LOG2-1:0]   r_row;
    logic [W_LOG2-1:0]   r_col;
    logic [3:0]          r_cmd;
    logic                r_pend_v;   // a ROM read is in flight, data arrives now
    logic [AW-1:0]       r_pend_a;   // address of the in-flight ROM read
    logic                r_issued;   // every ROM address has been issued
    logic [DW-1:0]       r_img [N];

    logic [H_LOG2-1:0]   w_row1;
    logic [W_LOG2-1:0]   w_col1;
    logic [AW-1:0]       w_a0, w_a1, w_a2, w_a3;
    logic [AW-1:0]       w_wr_next;
    logic [DW-1:0]       w_p0, w_p1, w_p2, w_p3;
    logic [DW-1:0]       w_max, w_min, w_avg;
    logic [DW+1:0]       w_sum;
    logic [DW-1:0]       w_n0, w_n1, w_n2, w_n3;
    logic                w_wr;
`ifdef LCD_MEDIAN_EN
    logic [DW:0]         w_mid;
    logic [DW-1:0]       w_med;
`endif

    assign w_row1    = r_row + 1'b1;
    assign w_col1    = r_col + 1'b1;
    assign w_a0      = {r_row,  r_col};
    assign w_a1      = {r_row,  w_col1};
    assign w_a2      = {w_row1, r_col};
    assign w_a3      = {w_row1, w_col1};
    assign w_wr_next = IRAM_A + 1'b1;

    // Window statistics and next pixel values for the pending command
    always_comb begin
        w_p0  = r_img[w_a0];
        w_p1  = r_img[w_a1];
        w_p2  = r_img[w_a2];
        w_p3  = r_img[w_a3];
        w_max = (w_p0 > w_p1) ? w_p0 : w_p1;
        if (w_p2 > w_max) w_max = w_p2;
        if (w_p3 > w_max) w_max = w_p3;
        w_min = (w_p0 < w_p1) ? w_p0 : w_p1;
        if (w_p2 < w_min) w_min = w_p2;
        if (w_p3 < w_min) w_min = w_p3;
        w_sum = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};
        w_avg = DW'(w_sum >> 2);
`ifdef LCD_MEDIAN_EN
        // Middle two of four sorted values sum to total minus extremes
        w_mid = (DW+1)'(w_sum - {2'b00, w_max} - {2'b00, w_min});
        w_med = DW'(w_mid >> 1);
`endif
        w_n0 = w_p0;
        w_n1 = w_p1;
        w_n2 = w_p2;
        w_n3 = w_p3;
        w_wr = 1'b0;
        case (r_cmd)
            4'd5:  begin w_n0 = w_max; w_n1 = w_max; w_n2 = w_max; w_n3 = w_max; w_wr = 1'b1; end
            4'd6:  begin w_n0 = w_min; w_n1 = w_min; w_n2 = w_min; w_n3 = w_min; w_wr = 1'b1; end
            4'd7:  begin w_n0 = w_avg; w_n1 = w_avg; w_n2 = w_avg; w_n3 = w_avg; w_wr = 1'b1; end
            4'd8:  begin w_n0 = w_p1;  w_n1 = w_p3;  w_n3 = w_p2;  w_n2 = w_p0;  w_wr = 1'b1; end
            4'd9:  begin w_n1 = w_p0;  w_n3 = w_p1;  w_n2 = w_p3;  w_n0 = w_p2;  w_wr = 1'b1; end
            4'd10: begin w_n0 = w_p2;  w_n2 = w_p0;  w_n1 = w_p3;  w_n3 = w_p1;  w_wr = 1'b1; end
            4'd11: begin w_n0 = w_p1;  w_n1 = w_p0;  w_n2 = w_p3;  w_n3 = w_p2;  w_wr = 1'b1; end
`ifdef LCD_MEDIAN_EN
            4'd12: begin w_n0 = w_med; w_n1 = w_med; w_n2 = w_med; w_n3 = w_med; w_wr = 1'b1; end
`endif
            default: w_wr = 1'b0;
        endcase
    end

    // Image storage: ROM capture during load, window update during EXEC.
    // No reset needed; reset forces LOAD with no read in flight.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && r_pend_v) begin
            r_img[r_pend_a] <= IROM_Q;
        end else if (r_state == S_EXEC && w_wr) begin
            r_img[w_a0] <= w_n0;
            r_img[w_a1] <= w_n1;
            r_img[w_a2] <= w_n2;
            r_img[w_a3] <= w_n3;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_LOAD;
            r_row      <= C_ROW_RST;
            r_col      <= C_COL_RST;
            r_cmd      <= 4'd0;
            r_pend_v   <= 1'b0;
            r_pend_a   <= '0;
            r_issued   <= 1'b0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_pend_v <= IROM_rd;
                    r_pend_a <= IROM_A;
                    if (IROM_rd) begin
                        if (IROM_A == C_LAST) begin
                            IROM_rd  <= 1'b0;
                            r_issued <= 1'b1;
                        end else begin
                            IROM_A <= IROM_A + 1'b1;
                        end
                    end else if (!r_issued) begin
                        IROM_rd <= 1'b1;
                    end else if (r_pend_v) begin
                        // final pixel lands on this edge
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && !busy) begin
                        r_cmd <= cmd;
                        busy  <= 1'b1;
                        if (cmd == 4'd0) begin
                            r_state    <= S_WRITE;
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= r_img[0];
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    case (r_cmd)
                        4'd1: if (r_row != '0)        r_row <= r_row - 1'b1;
                        4'd2: if (r_row != C_ROW_MAX) r_row <= w_row1;
                        4'd3: if (r_col != '0)        r_col <= r_col - 1'b1;
                        4'd4: if (r_col != C_COL_MAX) r_col <= w_col1;
                        default: r_row <= r_row;
                    endcase
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_WRITE: begin
                    if (IRAM_A == C_LAST) begin
                        IRAM_valid <= 1'b0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        IRAM_A <= w_wr_next;
                        IRAM_D <= r_img[w_wr_next];
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_img_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_img_ctrl_p
// Purpose  : Self-checking bench for lcd_img_ctrl_p (8x8/DW8 and 16x4/DW10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_img_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: 8x8, DW=8 ----------------
    logic       rst1, cv1, rd1, wv1, busy1, done1;
    logic [3:0] cmd1;
    logic [7:0] q1, wd1;
    logic [5:0] ra1, wa1;
    logic [7:0] rom1 [64];
    logic [7:0] exp1 [64];
    logic [7:0] got1 [64];

    lcd_img_ctrl_p #(.DW(8), .W_LOG2(3), .H_LOG2(3)) u_dut1 (
        .clk(clk), .reset(rst1), .cmd(cmd1), .cmd_valid(cv1), .IROM_Q(q1),
        .IROM_rd(rd1), .IROM_A(ra1), .IRAM_valid(wv1), .IRAM_D(wd1),
        .IRAM_A(wa1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) if (rd1) q1 <= rom1[ra1];

    // ---------------- DUT 2: 16x4, DW=10 ----------------
    logic       rst2, cv2, rd2, wv2, busy2, done2;
    logic [3:0] cmd2;
    logic [9:0] q2, wd2;
    logic [5:0] ra2, wa2;
    logic [9:0] rom2 [64];
    logic [9:0] exp2 [64];
    logic [9:0] got2 [64];

    lcd_img_ctrl_p #(.DW(10), .W_LOG2(4), .H_LOG2(2)) u_dut2 (
        .clk(clk), .reset(rst2), .cmd(cmd2), .cmd_valid(cv2), .IROM_Q(q2),
        .IROM_rd(rd2), .IROM_A(ra2), .IRAM_valid(wv2), .IRAM_D(wd2),
        .IRAM_A(wa2), .busy(busy2), .done(done2)
    );

    always @(posedge clk) if (rd2) q2 <= rom2[ra2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] cmd;
        int         org;
        logic [7:0] e0, e1, e2, e3;
    } vec_t;
    vec_t tv [16];

    int         cnt;
    logic       frd;
    logic [5:0] fa;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic vec_t mkv(input int c, input int o, input int a, input int b,
                                 input int d, input int e);
        vec_t v;
        v.cmd = 4'(c); v.org = o;
        v.e0 = 8'(a); v.e1 = 8'(b); v.e2 = 8'(d); v.e3 = 8'(e);
        return v;
    endfunction

    // ---------------- DUT 1 helpers ----------------
    task automatic load1(output int n, output logic r, output logic [5:0] a);
        @(negedge clk); rst1 = 1'b1; cv1 = 1'b0;
        @(negedge clk); rst1 = 1'b0;
        n = 0; r = 1'b0; a = '1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin r = rd1; a = ra1; end
            if (!busy1) break;
            n++;
        end
    endtask

    task automatic send1(input logic [3:0] c);
        @(negedge clk); cmd1 = c; cv1 = 1'b1;
        @(posedge clk); #1; cv1 = 1'b0;
        chk("acc_busy1", busy1, 1);
        if (c != 4'd0) begin
            @(posedge clk); #1;
            chk("exec_busy_1cyc1", busy1, 0);
        end
    endtask

    task automatic wrout1(input bit inject);
        int err;
        send1(4'd0);
        err = 0;
        for (int i = 0; i < 64; i++) begin
            if (!(wv1 === 1'b1 && wa1 === 6'(i) && busy1 === 1'b1 && done1 === 1'b0)) err++;
            got1[i] = wd1;
            if (inject && i == 10) begin cmd1 = 4'd5; cv1 = 1'b1; end
            if (inject && i == 11) cv1 = 1'b0;
            @(posedge clk); #1;
        end
        chk("wr_seq1", err, 0);
        chk("wr_end1", {wv1, done1, busy1}, 3'b010);
        @(posedge clk); #1;
        chk("done_pulse1", done1, 0);
    endtask

    task automatic exp_rom1();
        for (int k = 0; k < 64; k++) exp1[k] = rom1[k];
    endtask

    task automatic win1(input int b, input logic [7:0] v0, v1, v2, v3);
        exp1[b] = v0; exp1[b+1] = v1; exp1[b+8] = v2; exp1[b+9] = v3;
    endtask

    task automatic cmpimg1(input string nm);
        int first;
        first = 0;
        for (int k = 63; k >= 0; k--) if (got1[k] !== exp1[k]) first = k;
        chk($sformatf("%s@%0d", nm, first), got1[first], exp1[first]);
    endtask

    // ---------------- DUT 2 helpers ----------------
    task automatic load2(output int n);
        @(negedge clk); rst2 = 1'b1; cv2 = 1'b0;
        @(negedge clk); rst2 = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy2) break;
            n++;
        end
    endtask

    task automatic send2(input logic [3:0] c);
        @(negedge clk); cmd2 = c; cv2 = 1'b1;
        @(posedge clk); #1; cv2 = 1'b0;
        if (c != 4'd0) begin
            @(posedge clk); #1;
            chk("exec_busy_1cyc2", busy2, 0);
        end
    endtask

    task automatic wrout2();
        int err;
        send2(4'd0);
        err = 0;
        for (int i = 0; i < 64; i++) begin
            if (!(wv2 === 1'b1 && wa2 === 6'(i))) err++;
            got2[i] = wd2;
            @(posedge clk); #1;
        end
        chk("wr_seq2", err, 0);
        chk("wr_end2", {wv2, done2, busy2}, 3'b010);
    endtask

    task automatic win2(input int b, input logic [9:0] v0, v1, v2, v3);
        exp2[b] = v0; exp2[b+1] = v1; exp2[b+16] = v2; exp2[b+17] = v3;
    endtask

    initial begin
        rst1 = 1'b1; cv1 = 1'b0; cmd1 = 4'd0;
        rst2 = 1'b1; cv2 = 1'b0; cmd2 = 4'd0;
        for (int k = 0; k < 64; k++) rom1[k] = 8'(k);

        // Vector table: image holds 10,20,30,41 at 27/28/35/36 on entry
        tv[0]  = mkv(9,  27, 30, 10, 41, 20);
        tv[1]  = mkv(8,  27, 10, 20, 30, 41);
        tv[2]  = mkv(10, 27, 30, 41, 10, 20);
        tv[3]  = mkv(11, 27, 41, 30, 20, 10);
        tv[4]  = mkv(13, 27, 41, 30, 20, 10);
        tv[5]  = mkv(7,  27, 25, 25, 25, 25);
        tv[6]  = mkv(4,  28, 25, 29, 25, 37);
        tv[7]  = mkv(5,  28, 37, 37, 37, 37);
        tv[8]  = mkv(2,  36, 37, 37, 44, 45);
        tv[9]  = mkv(6,  36, 37, 37, 37, 37);
        tv[10] = mkv(3,  35, 25, 37, 43, 37);
        tv[11] = mkv(7,  35, 35, 35, 35, 35);
        tv[12] = mkv(1,  27, 25, 37, 35, 35);
        tv[13] = mkv(8,  27, 37, 35, 25, 35);
`ifdef LCD_MEDIAN_EN
        tv[14] = mkv(12, 27, 35, 35, 35, 35);
        tv[15] = mkv(15, 27, 35, 35, 35, 35);
`else
        tv[14] = mkv(12, 27, 37, 35, 25, 35);
        tv[15] = mkv(15, 27, 37, 35, 25, 35);
`endif

        // Reset values while reset is held
        @(posedge clk); @(posedge clk); #1;
        chk("rst_outs", {rd1, ra1, wv1, wd1, wa1, busy1, done1},
            {1'b0, 6'd0, 1'b0, 8'd0, 6'd0, 1'b1, 1'b0});

        // Load timing and ramp write-out
        load1(cnt, frd, fa);
        chk("load_cycles", cnt, 65);
        chk("load_first_rd_a", {frd, fa}, {1'b1, 6'd0});
        exp_rom1();
        wrout1(1'b0);
        cmpimg1("img_ramp");

        // Saturation of the window origin
        repeat (4) send1(4'd1);
        send1(4'd5);
        wrout1(1'b0);
        win1(3, 12, 12, 12, 12);
        cmpimg1("sat_up_org3");
        repeat (5) send1(4'd4);
        send1(4'd5);
        wrout1(1'b0);
        win1(6, 15, 15, 15, 15);
        cmpimg1("sat_right_org6");

        // Command strobe while busy must be ignored
        wrout1(1'b1);
        cmpimg1("busy_ignore");

        // Asynchronous reset during write-out
        send1(4'd0);
        for (int i = 0; i < 100; i++) begin
            if (wa1 == 6'd20) break;
            @(posedge clk); #1;
        end
        chk("reach_a20", wa1, 20);
        #2 rst1 = 1'b1;
        #1;
        chk("async_rst", {rd1, ra1, wv1, wd1, wa1, busy1, done1},
            {1'b0, 6'd0, 1'b0, 8'd0, 6'd0, 1'b1, 1'b0});
        load1(cnt, frd, fa);
        chk("reload_cycles", cnt, 65);
        send1(4'd5);
        wrout1(1'b0);
        exp_rom1();
        win1(27, 36, 36, 36, 36);
        cmpimg1("origin_after_rst");

        // Window with distinct values: max, min
        rom1[27] = 8'd10; rom1[28] = 8'd20; rom1[35] = 8'd30; rom1[36] = 8'd41;
        load1(cnt, frd, fa);
        send1(4'd5);
        wrout1(1'b0);
        exp_rom1();
        win1(27, 41, 41, 41, 41);
        cmpimg1("max_fill");
        load1(cnt, frd, fa);
        send1(4'd6);
        wrout1(1'b0);
        exp_rom1();
        win1(27, 10, 10, 10, 10);
        cmpimg1("min_fill");

        // Table-driven command sequence
        load1(cnt, frd, fa);
        exp_rom1();
        for (int i = 0; i < 16; i++) begin
            send1(tv[i].cmd);
            wrout1(1'b0);
            win1(tv[i].org, tv[i].e0, tv[i].e1, tv[i].e2, tv[i].e3);
            cmpimg1($sformatf("vec%0d_cmd%0d", i, tv[i].cmd));
        end

        // Second configuration: 16x4, DW=10, origin (1,7)=23
        for (int k = 0; k < 64; k++) rom2[k] = 10'(k);
        rom2[23] = 10'd1;    rom2[24] = 10'd5;    rom2[39] = 10'd9;    rom2[40] = 10'd100;
        rom2[30] = 10'd1023; rom2[31] = 10'd1023; rom2[46] = 10'd1023; rom2[47] = 10'd1023;
        load2(cnt);
        chk("load2_cycles", cnt, 65);
        send2(4'd12);
        repeat (9) send2(4'd4);
        send2(4'd7);
        wrout2();
        for (int k = 0; k < 64; k++) exp2[k] = rom2[k];
`ifdef LCD_MEDIAN_EN
        win2(23, 7, 7, 7, 7);
`endif
        win2(30, 1023, 1023, 1023, 1023);
        begin
            int first;
            first = 0;
            for (int k = 63; k >= 0; k--) if (got2[k] !== exp2[k]) first = k;
            chk($sformatf("dut2_img@%0d", first), got2[first], exp2[first]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_img_ctrl_p.md
Name: lcd_img_ctrl_p

Overview:
- Parametrised image-processing controller for the LCD path, generalised from the fixed 8x8 controller.
- Loads an IMG_W x IMG_H image from IROM into internal storage.
- Executes host commands on a movable 2x2 window: shift, max/min/average fill, rotate, mirror.
- Streams the image to IRAM on request. After write-out it returns to command mode, so the host may issue more commands and further write-outs.

Parameters:
- DW, 8, pixel width in bits.
- W_LOG2, 3, log2 of image width IMG_W (IMG_W >= 2).
- H_LOG2, 3, log2 of image height IMG_H (IMG_H >= 2).
- Derived, not overridable: AW = W_LOG2+H_LOG2; N = 2^AW.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command code.
- cmd_valid  in  1  command strobe.
- IROM_Q  in  DW  ROM read data, valid one cycle after IROM_A.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  AW  ROM address.
- IRAM_valid  out  1  RAM write strobe.
- IRAM_D  out  DW  RAM write data.
- IRAM_A  out  AW  RAM write address.
- busy  out  1  high while not accepting commands.
- done  out  1  one-cycle pulse at end of each write-out.

Behaviour:
- Reset values (asynchronous):
  - IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0.
  - Window origin (row,col) = (IMG_H/2-1, IMG_W/2-1); 8x8 gives address 27.
  - State = LOAD.
- States: LOAD, IDLE, EXEC, WRITE.
- LOAD:
  - First cycle after reset release: IROM_rd=1, IROM_A=0.
  - IROM_A increments each cycle up to N-1.
  - Pixel for address k is captured on the edge one cycle after IROM_A=k.
  - IROM_rd drops after address N-1 has been issued; the last pixel is captured on the following edge.
  - Then IDLE with busy=0. Load takes N+1 cycles; busy stays 1 throughout.
- IDLE:
  - A command is accepted on the edge where cmd_valid=1 and busy=0.
  - cmd_valid while busy=1 is ignored; no queuing.
  - Acceptance sets busy=1 on the next cycle and moves to EXEC, or to WRITE for cmd 0.
- EXEC (one cycle): applies the command below, then returns to IDLE. busy is high for exactly 1 cycle per command.
- Window pixels: p0=(r,c), p1=(r,c+1), p2=(r+1,c), p3=(r+1,c+1); address = row*IMG_W+col.
- Commands:
  - 0: write-out.
  - 1: up, r-1.
  - 2: down, r+1.
  - 3: left, c-1.
  - 4: right, c+1.
  - 1-4 saturate: r is clamped to 0..IMG_H-2 and c to 0..IMG_W-2; at the limit the origin is unchanged.
  - 5: all four pixels <= max.
  - 6: all four pixels <= min.
  - 7: all four pixels <= floor((p0+p1+p2+p3)/4), with the sum held at DW+2 bits and no overflow.
  - 8: rotate CCW: p0<=p1, p1<=p3, p3<=p2, p2<=p0.
  - 9: rotate CW: p1<=p0, p3<=p1, p2<=p3, p0<=p2.
  - 10: mirror X, swapping rows: p0<->p2, p1<->p3.
  - 11: mirror Y, swapping columns: p0<->p1, p2<->p3.
  - 12-15: reserved; no-op with the same 1-cycle busy.
  - The origin is unchanged by cmds 5-15.
- WRITE:
  - IRAM_valid=1 for exactly N consecutive cycles.
  - IRAM_A = 0..N-1, with IRAM_D = image[IRAM_A] in the same cycle.
  - The cycle after the last write: IRAM_valid=0, done=1 for one cycle, state=IDLE, busy=0.
  - The image and origin are retained.
- Reset asserted at any time, including mid-WRITE or mid-LOAD: immediate return to the reset values, followed by a full reload from IROM.

Optional Feature:
- LCD_MEDIAN_EN defined: cmd 12 performs median fill. All four pixels <= floor((second-smallest + second-largest)/2), computed at DW+1 bits.
- LCD_MEDIAN_EN undefined: cmd 12 is a reserved no-op, and no sorting logic is synthesised.

Test Plan:
- Reset, ROM pattern Q[k]=k, default 8x8 -> busy=1 for 65 cycles then busy=0. Then cmd 0 -> 64 IRAM writes with D=A, A=0..63, then a single done pulse.
- From reset origin 27: cmd 1 three times, then a fourth cmd 1 -> origin 3, then still 3 (saturated). cmd 4 x5 -> origin 6, not 7. cmd 0 -> image unchanged.
- Origin 27 with pixels 27,28,35,36 = 10,20,30,41 -> cmd 7 gives all 25, and image values at addresses 27/28/35/36 read back through cmd 0 all equal 25. Reload, then cmd 5 -> all 41; cmd 6 -> all 10.
- Same window, cmd 9 -> p0..p3 = 30,10,41,20. cmd 8 restores the original values. cmd 10 then cmd 11 -> 41,30,20,10.
- Pulse cmd_valid with cmd=5 while busy=1 during WRITE -> image unchanged. Assert reset at IRAM_A=20 -> outputs reset immediately, reload occurs, origin returns to 27.
- W_LOG2=4, H_LOG2=2, DW=10 -> load lasts 65 cycles, origin is (1,7)=23. Right saturates at c=14. Average of 1023 x4 = 1023. With LCD_MEDIAN_EN, cmd 12 on 1,5,9,100 gives 7.
